// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, state codes, ALUOp constants and decode helper (MIPS_BNE_EN adds bne).
package mips_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALUOP_AND   = 3'b000;
    localparam logic [2:0] ALUOP_OR    = 3'b001;
    localparam logic [2:0] ALUOP_ADD   = 3'b010;
    localparam logic [2:0] ALUOP_SUB   = 3'b110;
    localparam logic [2:0] ALUOP_FUNCT = 3'b111;

    function automatic state_t decode_next(input logic [5:0] op);
        return (op == OP_LW || op == OP_SW) ? S_MEMADR :
               (op == OP_RTYPE) ? S_EXEC :
               (op == OP_BEQ) ? S_BRANCH :
`ifdef MIPS_BNE_EN
               (op == OP_BNE) ? S_BRANCH :
`endif
               (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) ? S_IEXEC :
               (op == OP_J) ? S_JUMP : S_TRAP;
    endfunction
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational state/opcode to control-output decode (MIPS_BNE_EN adds bne).
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [0:2] alu_op,
    output logic       illegal
);
    logic pc_en_raw, mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    always_comb begin
        pc_en_raw     = 1'b0;
        iord          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_op        = ALUOP_AND;
        illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                alu_op       = ALUOP_ADD;
                ir_write_raw = mem_ready;
                pc_en_raw    = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                iord         = 1'b1;
                mem_read_raw = 1'b1;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
`ifdef MIPS_BNE_EN
                pc_en_raw = (opcode == OP_BNE) ? ~zero : zero;
`else
                pc_en_raw = zero;
`endif
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_ANDI) ? ALUOP_AND : (opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            S_IWB: reg_write_raw = 1'b1;
            S_JUMP: begin
                pc_src    = 2'b10;
                pc_en_raw = 1'b1;
            end
            S_TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

    // Reset overrides every enable immediately, not just from the next edge.
    assign pc_en     = pc_en_raw & ~reset;
    assign mem_read  = mem_read_raw & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign ir_write  = ir_write_raw & ~reset;
    assign reg_write = reg_write_raw & ~reset;
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM; define MIPS_BNE_EN to support bne.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [0:2] alu_op,
    output logic [3:0] state,
    output logic       illegal
);
    state_t cur, nxt;

    always_ff @(posedge clk)
        cur <= reset ? S_FETCH : nxt;

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: nxt = decode_next(opcode);
            S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            S_IEXEC:  nxt = S_IWB;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    assign state = cur;

    mips_ctrl_outdec u_outdec (
        .reset      (reset),
        .state      (cur),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .illegal    (illegal)
    );
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: random instruction stream vs per-instruction state-path model, queued per-cycle expectations.
module tb_mips_multicycle_control;
    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [0:2] alu_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .state      (state),
        .illegal    (illegal)
    );

    typedef logic [20:0] obs_t;
    obs_t exp_q[$];
    obs_t exp_v, act_v;
    int checks = 0, errors = 0, cycle = 0;
    int path[$];
    int idx = 0, code = 0, trap_cyc = 0, rst_hold = 0;
    logic prev_rst = 1'b1, prev_mr = 1'b0;

    // Sequence of state codes an instruction walks through; FETCH/MEMRD/MEMWR repeat while memory stalls.
    function void make_path(input logic [5:0] op);
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b001000, 6'b001100, 6'b001101: path = '{0, 1, 9, 10};
            6'b000100: path = '{0, 1, 8};
`ifdef MIPS_BNE_EN
            6'b000101: path = '{0, 1, 8};
`endif
            6'b000010: path = '{0, 1, 11};
            default:   path = '{0, 1, 12};
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
                                 6'b000100, 6'b000101, 6'b000010, 6'b111111, 6'b010101};
        return ops[$urandom_range(0, 10)];
    endfunction

    function automatic obs_t expect_for(int c, logic [5:0] op, logic z, logic mr, logic rst);
        logic pe = 0, io = 0, mrd = 0, mwr = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, il = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [2:0] ao = 3'b000;
        if (c == 0) begin mrd = 1; sb = 2'b01; ao = 3'b010; irw = mr; pe = mr; end
        if (c == 1) begin sb = 2'b11; ao = 3'b010; end
        if (c == 2) begin sa = 1; sb = 2'b10; ao = 3'b010; end
        if (c == 3) begin io = 1; mrd = 1; end
        if (c == 4) begin rw = 1; m2r = 1; end
        if (c == 5) begin io = 1; mwr = 1; end
        if (c == 6) begin sa = 1; ao = 3'b111; end
        if (c == 7) begin rw = 1; rd = 1; end
        if (c == 8) begin sa = 1; ao = 3'b110; ps = 2'b01; pe = (op == 6'b000101) ? !z : z; end
        if (c == 9) begin sa = 1; sb = 2'b10; ao = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b010; end
        if (c == 10) rw = 1;
        if (c == 11) begin ps = 2'b10; pe = 1; end
        if (c == 12) il = 1;
        if (rst) {pe, irw, mrd, mwr, rw} = 5'b0;
        return {c[3:0], pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ps, ao, il};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            #1;
            if (prev_rst) begin
                idx = 0;
                opcode = pick_op();
                make_path(opcode);
            end else if (path[idx] != 12 && !((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !prev_mr)) begin
                idx++;
                if (idx == path.size()) begin
                    idx = 0;
                    opcode = pick_op();
                    make_path(opcode);
                end
            end
            code = path[idx];
            trap_cyc = (code == 12) ? trap_cyc + 1 : 0;
            if (rst_hold == 0 && (trap_cyc >= 10 || $urandom_range(0, 59) == 0)) rst_hold = $urandom_range(1, 2);
            reset = rst_hold > 0;
            if (rst_hold > 0) rst_hold--;
            mem_ready = $urandom_range(0, 2) != 0;
            zero = 1'($urandom_range(0, 1));
            exp_q.push_back(expect_for(code, opcode, zero, mem_ready, reset));
            prev_rst = reset;
            prev_mr = mem_ready;
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial forever begin
        @(negedge clk);
        cycle++;
        checks++;
        if (mem_read === 1'b1 && mem_write === 1'b1) begin
            errors++;
            $display("FAIL mem_excl cycle %0d: mem_read=1 mem_write=1, required not both", cycle);
        end
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                     alu_src_a, alu_src_b, pc_src, alu_op, illegal};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL ctrl cycle %0d op=%b rst=%b: got state %0d vec %h, required state %0d vec %h",
                         cycle, opcode, reset, act_v[20:17], act_v, exp_v[20:17], exp_v);
            end
        end
    end
endmodule
